// File: rtl/iir_tdm_pkg.sv
// Shared types, coefficient indices and fixed-point helpers for the
// time-multiplexed biquad cascade.
package iir_tdm_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FB1  = 3'd1,
    FB2  = 3'd2,
    W0   = 3'd3,
    FF0  = 3'd4,
    FF1  = 3'd5,
    FF2  = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    MAC_HOLD = 2'd0,
    MAC_CLR  = 2'd1,
    MAC_ADD  = 2'd2,
    MAC_SUB  = 2'd3
  } mac_op_t;

  typedef enum logic [1:0] {
    D_W0 = 2'd0,
    D_W1 = 2'd1,
    D_W2 = 2'd2
  } dsel_t;

  // Coefficient order inside one section's 5-entry block.
  localparam logic [2:0] K_B0 = 3'd0;
  localparam logic [2:0] K_B1 = 3'd1;
  localparam logic [2:0] K_B2 = 3'd2;
  localparam logic [2:0] K_A1 = 3'd3;
  localparam logic [2:0] K_A2 = 3'd4;

  // Power-up coefficient: unity b0, everything else zero, so each section is a wire.
  function automatic logic [63:0] reset_coef(input logic [2:0] k, input int unsigned frac);
    if (k == K_B0) begin
      reset_coef = 64'd1 << frac;
    end else begin
      reset_coef = 64'd0;
    end
  endfunction

  // Round half-up at the binary point, then clamp to a signed out_w-bit range.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int unsigned frac,
                                                   input int unsigned out_w,
                                                   output logic clamped);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (acc + (64'sd1 <<< (frac - 32'd1))) >>> frac;
    hi = (64'sd1 <<< (out_w - 32'd1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 32'd1));
    if (r > hi) begin
      round_sat = hi;
      clamped   = 1'b1;
    end else if (r < lo) begin
      round_sat = lo;
      clamped   = 1'b1;
    end else begin
      round_sat = r;
      clamped   = 1'b0;
    end
  endfunction

endpackage

// File: rtl/iir_tdm_mac.sv
// Single shared multiplier with accumulator (hold/clear/add/subtract) and a
// round/saturate stage on the value being written into the accumulator.
module iir_tdm_mac
  import iir_tdm_pkg::*;
#(
  parameter int DATA_W    = 24,
  parameter int COEF_W    = 24,
  parameter int COEF_FRAC = 22,
  parameter int ACC_W     = DATA_W + COEF_W + 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  mac_op_t                  op,
  input  logic                     preload,
  input  logic signed [ACC_W-1:0]  bias,
  input  logic signed [COEF_W-1:0] coef,
  input  logic signed [DATA_W-1:0] data,
  output logic signed [DATA_W-1:0] result,
  output logic                     clamped
);

  localparam int PROD_W = COEF_W + DATA_W;

  logic signed [PROD_W-1:0] prod_s;
  logic signed [ACC_W-1:0]  prod_ext_s;
  logic signed [ACC_W-1:0]  base_s;
  logic signed [ACC_W-1:0]  acc_next_s;
  logic signed [ACC_W-1:0]  acc_r;

  // Multiply, pick the accumulation base and form the next accumulator value.
  always_comb begin
    prod_s     = coef * data;
    prod_ext_s = {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
    base_s     = preload ? bias : acc_r;
    case (op)
      MAC_CLR: acc_next_s = '0;
      MAC_ADD: acc_next_s = base_s + prod_ext_s;
      MAC_SUB: acc_next_s = base_s - prod_ext_s;
      default: acc_next_s = acc_r;
    endcase
  end

  // Round and saturate whatever is being written this cycle.
  always_comb begin
    clamped = 1'b0;
    result  = DATA_W'(round_sat({{(64-ACC_W){acc_next_s[ACC_W-1]}}, acc_next_s},
                                COEF_FRAC, DATA_W, clamped));
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= '0;
    end else begin
      acc_r <= acc_next_s;
    end
  end

endmodule

// File: rtl/iir_sos_tdm.sv
// Cascade of N_SOS direct-form-II biquads sharing one multiplier; six cycles
// per section. Define IIR_TRACE_EN to add trace_sec/trace_w0/trace_valid.
module iir_sos_tdm
  import iir_tdm_pkg::*;
#(
  parameter int DATA_W    = 24,
  parameter int COEF_W    = 24,
  parameter int COEF_FRAC = 22,
  parameter int N_SOS     = 4,
  parameter int ACC_W     = DATA_W + COEF_W + 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [DATA_W-1:0]                  data_in,
  input  logic                               data_valid_in,
  output logic                               data_ready_out,
  output logic [DATA_W-1:0]                  data_out,
  output logic                               data_valid_out,
  output logic                               ovf_out,
  input  logic                               coef_we,
  input  logic [$clog2(32'd5*N_SOS)-1:0]     coef_addr,
  input  logic [COEF_W-1:0]                  coef_wdata,
  output logic                               coef_drop,
  input  logic                               state_clr
`ifdef IIR_TRACE_EN
  ,
  output logic [3:0]                         trace_sec,
  output logic [DATA_W-1:0]                  trace_w0,
  output logic                               trace_valid
`endif
);

  localparam int CA_W  = $clog2(32'd5 * N_SOS);
  localparam int SEC_W = (N_SOS > 1) ? $clog2(N_SOS) : 1;

  state_t                   state_r, state_n_s;
  mac_op_t                  mac_op_s;
  logic                     preload_s;
  logic signed [ACC_W-1:0]  bias_s;
  logic [2:0]               k_sel_s;
  dsel_t                    dsel_s;
  logic signed [COEF_W-1:0] coef_s;
  logic signed [DATA_W-1:0] opnd_s;
  logic signed [DATA_W-1:0] mac_y_s;
  logic                     mac_sat_s;

  logic [SEC_W-1:0]         sec_r;
  logic signed [DATA_W-1:0] x_r, w0_r;
  logic signed [DATA_W-1:0] w1_r [N_SOS];
  logic signed [DATA_W-1:0] w2_r [N_SOS];
  logic signed [COEF_W-1:0] coef_r [N_SOS][5];
  logic                     ovf_acc_r;
  logic                     idle_s, accept_s, last_s;

  assign idle_s         = (state_r == IDLE);
  assign accept_s       = idle_s && data_valid_in && !state_clr;
  assign last_s         = (sec_r == SEC_W'(N_SOS - 32'sd1));
  assign data_ready_out = idle_s;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Next state plus MAC opcode and operand selection for each step.
  always_comb begin
    state_n_s = state_r;
    mac_op_s  = MAC_HOLD;
    preload_s = 1'b0;
    bias_s    = '0;
    k_sel_s   = K_B0;
    dsel_s    = D_W0;
    if (state_clr) begin
      state_n_s = IDLE;
      mac_op_s  = MAC_CLR;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) state_n_s = FB1;
          else          state_n_s = IDLE;
        end
        FB1: begin
          mac_op_s  = MAC_SUB;
          preload_s = 1'b1;
          bias_s    = {{(ACC_W-DATA_W-COEF_FRAC){x_r[DATA_W-1]}}, x_r, {COEF_FRAC{1'b0}}};
          k_sel_s   = K_A1;
          dsel_s    = D_W1;
          state_n_s = FB2;
        end
        FB2: begin
          mac_op_s  = MAC_SUB;
          k_sel_s   = K_A2;
          dsel_s    = D_W2;
          state_n_s = W0;
        end
        W0: state_n_s = FF0;
        FF0: begin
          mac_op_s  = MAC_ADD;
          preload_s = 1'b1;
          k_sel_s   = K_B0;
          dsel_s    = D_W0;
          state_n_s = FF1;
        end
        FF1: begin
          mac_op_s  = MAC_ADD;
          k_sel_s   = K_B1;
          dsel_s    = D_W1;
          state_n_s = FF2;
        end
        FF2: begin
          mac_op_s  = MAC_ADD;
          k_sel_s   = K_B2;
          dsel_s    = D_W2;
          if (last_s) state_n_s = IDLE;
          else        state_n_s = FB1;
        end
        default: state_n_s = IDLE;
      endcase
    end
  end

  // Route the current section's coefficient and state word to the multiplier.
  always_comb begin
    coef_s = coef_r[sec_r][k_sel_s];
    case (dsel_s)
      D_W1:    opnd_s = w1_r[sec_r];
      D_W2:    opnd_s = w2_r[sec_r];
      default: opnd_s = w0_r;
    endcase
  end

  iir_tdm_mac #(
    .DATA_W    (DATA_W),
    .COEF_W    (COEF_W),
    .COEF_FRAC (COEF_FRAC),
    .ACC_W     (ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .op      (mac_op_s),
    .preload (preload_s),
    .bias    (bias_s),
    .coef    (coef_s),
    .data    (opnd_s),
    .result  (mac_y_s),
    .clamped (mac_sat_s)
  );

  // Section state, cascade carry and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_r          <= '0;
      x_r            <= '0;
      w0_r           <= '0;
      ovf_acc_r      <= 1'b0;
      data_out       <= '0;
      data_valid_out <= 1'b0;
      ovf_out        <= 1'b0;
      for (int s = 0; s < N_SOS; s++) begin
        w1_r[s] <= '0;
        w2_r[s] <= '0;
      end
    end else if (state_clr) begin
      sec_r          <= '0;
      x_r            <= '0;
      w0_r           <= '0;
      ovf_acc_r      <= 1'b0;
      data_valid_out <= 1'b0;
      for (int s = 0; s < N_SOS; s++) begin
        w1_r[s] <= '0;
        w2_r[s] <= '0;
      end
    end else begin
      data_valid_out <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            x_r       <= data_in;
            sec_r     <= '0;
            ovf_acc_r <= 1'b0;
          end
        end
        W0: begin
          w0_r      <= mac_y_s;
          ovf_acc_r <= ovf_acc_r | mac_sat_s;
        end
        FF2: begin
          w2_r[sec_r] <= w1_r[sec_r];
          w1_r[sec_r] <= w0_r;
          x_r         <= mac_y_s;
          ovf_acc_r   <= ovf_acc_r | mac_sat_s;
          if (last_s) begin
            data_out       <= mac_y_s;
            ovf_out        <= ovf_acc_r | mac_sat_s;
            data_valid_out <= 1'b1;
          end else begin
            sec_r <= sec_r + SEC_W'(32'd1);
          end
        end
        default: ;
      endcase
    end
  end

  // Coefficient file: writes land only while idle and not accepting a sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef_drop <= 1'b0;
      for (int s = 0; s < N_SOS; s++) begin
        for (int k = 0; k < 5; k++) begin
          coef_r[s][k] <= COEF_W'(reset_coef(3'(k), COEF_FRAC));
        end
      end
    end else begin
      coef_drop <= 1'b0;
      if (coef_we) begin
        if (idle_s && !accept_s) begin
          for (int s = 0; s < N_SOS; s++) begin
            for (int k = 0; k < 5; k++) begin
              if (coef_addr == CA_W'(32'sd5 * s + k)) begin
                coef_r[s][k] <= coef_wdata;
              end
            end
          end
        end else begin
          coef_drop <= 1'b1;
        end
      end
    end
  end

`ifdef IIR_TRACE_EN
  // Expose each section's freshly computed w0 for capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trace_sec   <= 4'd0;
      trace_w0    <= '0;
      trace_valid <= 1'b0;
    end else begin
      trace_valid <= (state_r == W0) && !state_clr;
      trace_sec   <= 4'(sec_r);
      if ((state_r == W0) && !state_clr) begin
        trace_w0 <= mac_y_s;
      end
    end
  end
`endif

endmodule

// File: tb/tb_iir_sos_tdm.sv
// Scoreboard bench for iir_sos_tdm: stimulus pushes model results, a monitor
// pops and compares on every data_valid_out pulse.
module tb_iir_sos_tdm;

  localparam int DATA_W    = 24;
  localparam int COEF_W    = 24;
  localparam int COEF_FRAC = 22;
  localparam int N_SOS     = 4;
  localparam int CA_W      = $clog2(5 * N_SOS);
  localparam int LAT       = 6 * N_SOS + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] data_in;
  logic              data_valid_in;
  logic              data_ready_out;
  logic [DATA_W-1:0] data_out;
  logic              data_valid_out;
  logic              ovf_out;
  logic              coef_we;
  logic [CA_W-1:0]   coef_addr;
  logic [COEF_W-1:0] coef_wdata;
  logic              coef_drop;
  logic              state_clr;

  always #5 clk = ~clk;

  iir_sos_tdm dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_in        (data_in),
    .data_valid_in  (data_valid_in),
    .data_ready_out (data_ready_out),
    .data_out       (data_out),
    .data_valid_out (data_valid_out),
    .ovf_out        (ovf_out),
    .coef_we        (coef_we),
    .coef_addr      (coef_addr),
    .coef_wdata     (coef_wdata),
    .coef_drop      (coef_drop),
    .state_clr      (state_clr)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int out_count = 0;
  int last_accept = 0;

  typedef struct {
    logic [DATA_W-1:0] d;
    bit                o;
    int                e;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: per-section coefficients and delay-line words.
  longint mc [N_SOS][5];
  longint mw1 [N_SOS];
  longint mw2 [N_SOS];

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  function automatic longint q_round_sat(input longint acc, inout bit ov);
    longint r;
    longint top;
    top = longint'(1) << (DATA_W - 1);
    r = (acc + (longint'(1) << (COEF_FRAC - 1))) >>> COEF_FRAC;
    if (r > top - 1) begin ov = 1'b1; return top - 1; end
    if (r < -top)    begin ov = 1'b1; return -top; end
    return r;
  endfunction

  function automatic void model_coef_reset();
    for (int s = 0; s < N_SOS; s++)
      for (int k = 0; k < 5; k++)
        mc[s][k] = (k == 0) ? (longint'(1) << COEF_FRAC) : 0;
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < N_SOS; s++) begin mw1[s] = 0; mw2[s] = 0; end
  endfunction

  // Run one sample through the whole cascade: coefficients are b0,b1,b2,a1,a2.
  function automatic void model_run(input longint x, output longint y, output bit ov);
    longint v, w0;
    v = x; ov = 1'b0;
    for (int s = 0; s < N_SOS; s++) begin
      w0 = q_round_sat(v * (longint'(1) << COEF_FRAC) - mc[s][3] * mw1[s] - mc[s][4] * mw2[s], ov);
      v  = q_round_sat(mc[s][0] * w0 + mc[s][1] * mw1[s] + mc[s][2] * mw2[s], ov);
      mw2[s] = mw1[s];
      mw1[s] = w0;
    end
    y = v;
  endfunction

  // Monitor: compare every output pulse against the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && data_valid_out) begin
      out_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("data_out", longint'($signed(data_out)), longint'($signed(e.d)));
        check("ovf_out", longint'(ovf_out), longint'(e.o));
        check("latency", longint'(cyc + 1 - e.e), longint'(LAT));
      end
    end
  end

  // Present a sample (called at a negedge); holds valid until accepted.
  task automatic send(input logic [DATA_W-1:0] x, input bit expect_out);
    int t;
    longint y;
    bit ov;
    exp_t e;
    data_in = x;
    data_valid_in = 1'b1;
    t = 0;
    while (!data_ready_out && t < 4 * LAT) begin @(negedge clk); t++; end
    if (!data_ready_out) begin
      check("accept_timeout", 0, 1);
      data_valid_in = 1'b0;
      return;
    end
    last_accept = cyc + 1;
    if (expect_out) begin
      model_run(longint'($signed(x)), y, ov);
      e.d = DATA_W'(y); e.o = ov; e.e = cyc + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    data_valid_in = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || !data_ready_out) && t < 4 * LAT) begin @(negedge clk); t++; end
    if (exp_q.size() != 0 || !data_ready_out) check("drain_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic write_coef(input int addr, input logic [COEF_W-1:0] val);
    int t;
    t = 0;
    while (!data_ready_out && t < 4 * LAT) begin @(negedge clk); t++; end
    coef_addr = CA_W'(addr);
    coef_wdata = val;
    coef_we = 1'b1;
    @(negedge clk);
    coef_we = 1'b0;
    check("coef_drop_idle", longint'(coef_drop), 0);
    if (addr < 5 * N_SOS) mc[addr / 5][addr % 5] = longint'($signed(val));
  endtask

  task automatic clr_state();
    state_clr = 1'b1;
    @(negedge clk);
    state_clr = 1'b0;
    model_clear();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0, a1;
    logic [DATA_W-1:0] v;
    logic [COEF_W-1:0] cv;
    rst_n = 1'b0; data_in = '0; data_valid_in = 1'b0; coef_we = 1'b0;
    coef_addr = '0; coef_wdata = '0; state_clr = 1'b0;
    model_coef_reset(); model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_data_out", longint'(data_out), 0);
    check("rst_valid", longint'(data_valid_out), 0);
    check("rst_ovf", longint'(ovf_out), 0);
    check("rst_coef_drop", longint'(coef_drop), 0);
    check("rst_ready", longint'(data_ready_out), 1);

    // Passthrough after reset.
    send(24'd1000, 1'b1); wait_drain();
    check("passthru", longint'($signed(data_out)), 1000);

    // Gain of one half in section 0.
    write_coef(0, 24'h200000);
    send(24'd4000, 1'b1); wait_drain();
    check("gain_half", longint'($signed(data_out)), 2000);

    // First-order recursion with a1 = -0.5.
    write_coef(0, 24'h400000);
    write_coef(3, 24'hE00000);
    clr_state();
    send(24'h100000, 1'b1); wait_drain();
    check("recur0", longint'($signed(data_out)), 64'h100000);
    send(24'h0, 1'b1); wait_drain();
    check("recur1", longint'($signed(data_out)), 64'h080000);
    send(24'h0, 1'b1); wait_drain();
    check("recur2", longint'($signed(data_out)), 64'h040000);

    // Saturation through every section.
    write_coef(3, 24'h0);
    for (int s = 0; s < N_SOS; s++) write_coef(5 * s, 24'h7FFFFF);
    clr_state();
    send(24'h7FFFFF, 1'b1); wait_drain();
    check("sat_data", longint'(data_out), 64'h7FFFFF);
    check("sat_ovf", longint'(ovf_out), 1);
    for (int s = 0; s < N_SOS; s++) write_coef(5 * s, 24'h400000);
    clr_state();

    // Back-to-back samples with valid held through the busy period.
    send(24'd1234, 1'b1);
    a1 = last_accept;
    v = -24'sd5678;
    send(v, 1'b1);
    check("b2b_spacing", longint'(last_accept - a1), longint'(LAT));
    wait_drain();

    // Coefficient write while busy is dropped and leaves b0 untouched.
    send(24'd777, 1'b1);
    repeat (3) @(negedge clk);
    coef_addr = '0; coef_wdata = 24'h123456; coef_we = 1'b1;
    @(negedge clk);
    coef_we = 1'b0;
    check("coef_drop_busy", longint'(coef_drop), 1);
    wait_drain();
    send(24'd500, 1'b1); wait_drain();
    check("coef_kept", longint'($signed(data_out)), 500);

    // Abort mid-sample, then clear together with a valid sample.
    write_coef(3, 24'hE00000);
    clr_state();
    send(24'h100000, 1'b1); wait_drain();
    cnt0 = out_count;
    send(24'h200000, 1'b0);
    repeat (8) @(negedge clk);
    clr_state();
    state_clr = 1'b1; data_in = 24'd42; data_valid_in = 1'b1;
    @(negedge clk);
    state_clr = 1'b0; data_valid_in = 1'b0;
    repeat (2 * LAT) @(negedge clk);
    check("abort_no_output", longint'(out_count), longint'(cnt0));
    send(24'h100000, 1'b1); wait_drain();
    check("abort_fresh", longint'($signed(data_out)), 64'h100000);

    // Reset in the middle of a sample.
    cnt0 = out_count;
    send(24'd999, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", longint'(data_ready_out), 1);
    check("midrst_data", longint'(data_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_coef_reset(); model_clear();
    repeat (LAT + 5) @(negedge clk);
    check("midrst_no_output", longint'(out_count), longint'(cnt0));
    send(24'd321, 1'b1); wait_drain();

    // Random coefficients (including out-of-range addresses) and samples.
    for (int i = 0; i < 40; i++) begin
      cv = COEF_W'($urandom_range(0, 32'h1FFFFF)) - COEF_W'(32'h100000);
      write_coef(int'($urandom_range(0, (1 << CA_W) - 1)), cv);
    end
    clr_state();
    for (int i = 0; i < 24; i++) begin
      v = DATA_W'($urandom);
      send(v, 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drain();
    check("queue_empty", longint'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
